branch_predict_unit: RTL and testbench

- Parametrised successor to the single-table branch resolver: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters, plus EX-stage resolution logic.
- Fetch-side lookup is combinational and same-cycle. Table update on resolution is registered.
- Sits between PC/IF (prediction) and ID/EX (resolution). Drives the pipeline flush mask and the redirect address on a mispredict.

---
 rtl/branch_predict_unit.sv | 98 +++++++++
 tb/tb_branch_predict_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating direction counters and EX-stage resolve/flush logic
// Optional: define BRANCH_PERF_CNT_EN to add the perf_branches / perf_mispredicts counters.
module branch_predict_unit #(
    parameter int ADDR_WIDTH     = 16,
    parameter int INDEX_BITS     = 4,
    parameter int CTR_BITS       = 2,
    parameter int NUM_PIPE_MASKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     lookup_pc,
    output logic                      predict_taken,
    output logic [ADDR_WIDTH-1:0]     predict_target,
    input  logic                      resolve_valid,
    input  logic                      resolve_indirect,
    input  logic                      resolve_taken,
    input  logic [ADDR_WIDTH-1:0]     resolve_pc,
    input  logic [ADDR_WIDTH-1:0]     resolve_target,
    input  logic                      resolve_pred_taken,
    input  logic [ADDR_WIDTH-1:0]     resolve_pred_target,
    input  logic                      invalidate,
`ifdef BRANCH_PERF_CNT_EN
    output logic [31:0]               perf_branches,
    output logic [31:0]               perf_mispredicts,
`endif
    output logic [NUM_PIPE_MASKS-1:0] flush,
    output logic [ADDR_WIDTH-1:0]     redirect_address
);
    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [DEPTH-1:0]      valid;
    logic [TAG_W-1:0]      tag    [DEPTH];
    logic [ADDR_WIDTH-1:0] target [DEPTH];
    logic [CTR_BITS-1:0]   ctr    [DEPTH];

    logic [INDEX_BITS-1:0] l_idx, r_idx;
    logic [TAG_W-1:0]      r_tag;
    logic [CTR_BITS-1:0]   r_ctr, ctr_next;
    logic                  l_hit, r_hit, act_taken, mispredict;

    // Fetch lookup, resolve classification and next counter value
    always_comb begin
        l_idx            = lookup_pc[INDEX_BITS-1:0];
        r_idx            = resolve_pc[INDEX_BITS-1:0];
        r_tag            = resolve_pc[ADDR_WIDTH-1:INDEX_BITS];
        r_ctr            = ctr[r_idx];
        l_hit            = valid[l_idx] && tag[l_idx] == lookup_pc[ADDR_WIDTH-1:INDEX_BITS];
        r_hit            = valid[r_idx] && tag[r_idx] == r_tag;
        predict_taken    = l_hit && ctr[l_idx][CTR_BITS-1];
        predict_target   = predict_taken ? target[l_idx] : '0;
        act_taken        = resolve_indirect || resolve_taken;
        mispredict       = resolve_valid && (act_taken != resolve_pred_taken ||
                           (act_taken && resolve_pred_taken && resolve_target != resolve_pred_target));
        flush            = mispredict ? '1 : (resolve_valid && act_taken) ? NUM_PIPE_MASKS'(1) : '0;
        redirect_address = act_taken ? resolve_target : resolve_pc + ADDR_WIDTH'(1);
        ctr_next         = !act_taken ? (r_ctr == '0 ? '0 : r_ctr - CTR_BITS'(1)) :
                           resolve_indirect ? CTR_MAX :
                           !r_hit ? CTR_WEAK :
                           r_ctr == CTR_MAX ? CTR_MAX : r_ctr + CTR_BITS'(1);
    end

    // Table update: invalidate beats resolution; a not-taken miss leaves the table alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i]    <= '0;
                tag[i]    <= '0;
                target[i] <= '0;
            end
        end else if (invalidate) begin
            valid <= '0;
        end else if (resolve_valid && (r_hit || act_taken)) begin
            valid[r_idx] <= 1'b1;
            ctr[r_idx]   <= ctr_next;
            if (act_taken) begin
                tag[r_idx]    <= r_tag;
                target[r_idx] <= resolve_target;
            end
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Saturating resolve and mispredict counters, frozen on invalidate cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (!invalidate) begin
            if (resolve_valid && perf_branches != '1) perf_branches <= perf_branches + 32'd1;
            if (mispredict && perf_mispredicts != '1) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plus randomized checks of branch_predict_unit against a table model
module tb_branch_predict_unit;
    localparam int DEPTH = 16;
    localparam int CMAX  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] lookup_pc = '0;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        resolve_valid = 1'b0;
    logic        resolve_indirect = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [15:0] resolve_pc = '0;
    logic [15:0] resolve_target = '0;
    logic        resolve_pred_taken = 1'b0;
    logic [15:0] resolve_pred_target = '0;
    logic        invalidate = 1'b0;
    logic [3:0]  flush;
    logic [15:0] redirect_address;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .resolve_valid(resolve_valid), .resolve_indirect(resolve_indirect),
        .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
        .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_target(resolve_pred_target), .invalidate(invalidate),
`ifdef BRANCH_PERF_CNT_EN
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
        .flush(flush), .redirect_address(redirect_address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit     m_valid [DEPTH];
    int     m_tag   [DEPTH];
    int     m_tgt   [DEPTH];
    int     m_ctr   [DEPTH];
    longint m_br = 0;
    longint m_mp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void m_lookup(input int pc, output bit tk, output int tg);
        int i;
        i  = pc % DEPTH;
        tk = m_valid[i] && m_tag[i] == pc / DEPTH && m_ctr[i] >= 2;
        tg = tk ? m_tgt[i] : 0;
    endfunction

    function automatic bit m_act();
        return resolve_indirect || resolve_taken;
    endfunction

    function automatic bit m_mis();
        if (!resolve_valid) return 0;
        if (m_act() != resolve_pred_taken) return 1;
        return m_act() && int'(resolve_target) != int'(resolve_pred_target);
    endfunction

    function automatic void m_update();
        int i, pc;
        bit hit;
        if (!reset) return;
        if (invalidate) begin
            for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
            return;
        end
        if (!resolve_valid) return;
        m_br++;
        if (m_mis()) m_mp++;
        pc  = int'(resolve_pc);
        i   = pc % DEPTH;
        hit = m_valid[i] && m_tag[i] == pc / DEPTH;
        if (m_act()) begin
            m_ctr[i]   = resolve_indirect ? CMAX : hit ? (m_ctr[i] < CMAX ? m_ctr[i] + 1 : CMAX) : 2;
            m_valid[i] = 1;
            m_tag[i]   = pc / DEPTH;
            m_tgt[i]   = int'(resolve_target);
        end else if (hit) begin
            m_ctr[i] = m_ctr[i] > 0 ? m_ctr[i] - 1 : 0;
        end
    endfunction

    task automatic drive(input int lpc, input bit rv, input bit ind, input bit tk, input int rpc,
                         input int rt, input bit ptk, input int ppt, input bit inv);
        lookup_pc           = 16'(lpc);
        resolve_valid       = rv;
        resolve_indirect    = ind;
        resolve_taken       = tk;
        resolve_pc          = 16'(rpc);
        resolve_target      = 16'(rt);
        resolve_pred_taken  = ptk;
        resolve_pred_target = 16'(ppt);
        invalidate          = inv;
    endtask

    task automatic step();
        bit et;
        int etg, ef, er;
        #1;
        m_lookup(int'(lookup_pc), et, etg);
        ef = m_mis() ? 15 : (resolve_valid && m_act()) ? 1 : 0;
        er = m_act() ? int'(resolve_target) : (int'(resolve_pc) + 1) % 65536;
        chk("predict_taken", 64'(predict_taken), 64'(et));
        chk("predict_target", 64'(predict_target), 64'(etg));
        chk("flush", 64'(flush), 64'(ef));
        chk("redirect_address", 64'(redirect_address), 64'(er));
        @(posedge clk);
        m_update();
        #1;
`ifdef BRANCH_PERF_CNT_EN
        chk("perf_branches", 64'(perf_branches), 64'(m_br));
        chk("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mp));
`endif
    endtask

    function automatic int rnd_pc();
        return $urandom_range(0, 5) == 0 ? int'($urandom_range(16'hFFF0, 16'hFFFF)) : int'($urandom_range(0, 63));
    endfunction

    initial begin
        int rpc, etg;
        bit et;
        m_reset();
        drive(16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_predict_taken", 64'(predict_taken), 64'(0));
        chk("reset_predict_target", 64'(predict_target), 64'(0));
        step();
        reset = 1'b1;
        drive(16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_reset_taken", 64'(predict_taken), 64'(0));
        step();
        drive(16'h10, 1, 0, 1, 16'h10, 16'h40, 0, 0, 0);
        #1;
        chk("alloc_flush", 64'(flush), 64'hF);
        chk("alloc_redirect", 64'(redirect_address), 64'h40);
        step();
        drive(16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alloc_lookup_taken", 64'(predict_taken), 64'(1));
        chk("alloc_lookup_target", 64'(predict_target), 64'h40);
        step();
        drive(16'h10, 1, 0, 0, 16'h10, 0, 1, 16'h40, 0);
        #1;
        chk("nt1_flush", 64'(flush), 64'hF);
        chk("nt1_redirect", 64'(redirect_address), 64'h11);
        step();
        drive(16'h10, 1, 0, 0, 16'h10, 0, 0, 0, 0);
        #1;
        chk("nt2_flush", 64'(flush), 64'(0));
        step();
        drive(16'h10, 1, 0, 1, 16'h10, 16'h44, 0, 0, 0);
        step();
        drive(16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("still_valid_ctr1", 64'(predict_taken), 64'(0));
        step();
        drive(0, 1, 0, 1, 16'h20, 16'h55, 0, 0, 0);
        step();
        drive(16'h20, 1, 0, 1, 16'h30, 16'h66, 0, 0, 0);
        #1;
        chk("read_before_write_taken", 64'(predict_taken), 64'(1));
        chk("read_before_write_target", 64'(predict_target), 64'h55);
        step();
        drive(16'h20, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alias_evicted", 64'(predict_taken), 64'(0));
        step();
        drive(16'h30, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alias_new_target", 64'(predict_target), 64'h66);
        step();
        drive(16'hFF, 1, 1, 0, 16'hFF, 16'h200, 1, 16'h100, 0);
        #1;
        chk("jr_flush", 64'(flush), 64'hF);
        chk("jr_redirect", 64'(redirect_address), 64'h200);
        step();
        drive(16'hFF, 1, 0, 0, 16'hFF, 0, 1, 16'h200, 0);
        #1;
        chk("jr_lookup_target", 64'(predict_target), 64'h200);
        chk("jr_then_nt_redirect", 64'(redirect_address), 64'h100);
        step();
        drive(16'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("jr_ctr_strong", 64'(predict_taken), 64'(1));
        step();
        drive(0, 1, 0, 0, 16'hFFFF, 0, 1, 16'h1234, 0);
        #1;
        chk("wrap_flush", 64'(flush), 64'hF);
        chk("wrap_redirect", 64'(redirect_address), 64'(0));
        step();
        drive(16'hFF, 1, 0, 1, 16'h40, 16'h77, 0, 0, 1);
        step();
        foreach (m_valid[i]) begin
            drive(i * 16 + 15, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(16'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("inval_no_alloc", 64'(predict_taken), 64'(0));
        step();
        drive(16'h50, 1, 0, 1, 16'h50, 16'h99, 0, 0, 0);
        step();
        drive(16'h50, 1, 0, 1, 16'h71, 16'hAA, 0, 0, 0);
        #1;
        chk("pre_async_hit", 64'(predict_taken), 64'(1));
        reset = 1'b0;
        m_reset();
        #1;
        chk("async_reset_taken", 64'(predict_taken), 64'(0));
        chk("async_reset_target", 64'(predict_target), 64'(0));
        step();
        step();
        reset = 1'b1;
        drive(16'h71, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("no_update_in_reset", 64'(predict_taken), 64'(0));
        step();
        for (int n = 0; n < 500; n++) begin
            rpc = rnd_pc();
            m_lookup(rpc, et, etg);
            if ($urandom_range(0, 3) == 0) begin
                et  = 1'($urandom_range(0, 1));
                etg = int'($urandom_range(0, 3)) * 16'h0111;
            end
            drive(rnd_pc(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                  rpc, int'($urandom_range(0, 3)) * 16'h0111, et, etg, $urandom_range(0, 31) == 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
